// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_WAIT = 2'd1,
        M_ERR  = 2'd2
    } mem_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [3:0] REG_PC = 4'd15;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// hazard controller (slave).
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [3:0] RA1D, RA2D, RA1E, RA2E;
    logic [3:0] WA3E, WA3M, WA3W;
    logic       RegWriteM, RegWriteW;
    logic       MemtoRegE;
    logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW;
    logic       BranchTakenE;
    logic       MemAccessM, MemReadyM;

    logic       StallF, StallD, StallE, StallM;
    logic       FlushD, FlushE, FlushW;
    logic [1:0] ForwardAE, ForwardBE;
    logic       MemError;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
               RegWriteM, RegWriteW, MemtoRegE,
               PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE,
               MemAccessM, MemReadyM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, MemError, StallCount
    );

    modport slave (
        input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
               RegWriteM, RegWriteW, MemtoRegE,
               PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE,
               MemAccessM, MemReadyM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, MemError, StallCount
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// Per-operand execute-stage forwarding select; memory stage wins over
// writeback, and the PC register is never forwarded.
module forward_unit
    import hazard_pkg::*;
(
    input  logic [3:0] ra,
    input  logic [3:0] wa_mem,
    input  logic [3:0] wa_wb,
    input  logic       we_mem,
    input  logic       we_wb,
    output logic [1:0] sel
);

    // Priority select: memory result, then writeback result, else register file.
    always_comb begin
        sel = FWD_RF;
        if (ra != REG_PC) begin
            if (we_mem && (wa_mem == ra)) begin
                sel = FWD_MEM;
            end else if (we_wb && (wa_wb == ra)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard/sequencing controller for the 5-stage pipeline: stall and
// flush controls, operand forwarding, data-memory wait-state FSM, stall
// performance counter and sticky memory-timeout error.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave hz
);

    mem_state_t       state, state_nxt;
    logic [4:0]       wait_cnt, wait_cnt_nxt;
    logic [CNT_W-1:0] stall_count;

    logic ld_stall;
    logic pc_pend;
    logic mem_stall;
    logic halt;
    logic stall_f;

    forward_unit u_fwd_a (
        .ra     (hz.RA1E),
        .wa_mem (hz.WA3M),
        .wa_wb  (hz.WA3W),
        .we_mem (hz.RegWriteM),
        .we_wb  (hz.RegWriteW),
        .sel    (hz.ForwardAE)
    );

    forward_unit u_fwd_b (
        .ra     (hz.RA2E),
        .wa_mem (hz.WA3M),
        .wa_wb  (hz.WA3W),
        .we_mem (hz.RegWriteM),
        .we_wb  (hz.RegWriteW),
        .sel    (hz.ForwardBE)
    );

    assign ld_stall  = hz.MemtoRegE && ((hz.WA3E == hz.RA1D) || (hz.WA3E == hz.RA2D));
    assign pc_pend   = hz.PCSrcD || hz.PCSrcE || hz.PCSrcM;
    assign mem_stall = hz.MemAccessM && !hz.MemReadyM && (state != M_ERR);
    assign halt      = (state == M_ERR) || mem_stall;

    // Memory FSM state and wait counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= M_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Memory FSM next-state: count wait cycles until ready or timeout.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        unique case (state)
            M_IDLE: begin
                if (hz.MemAccessM && !hz.MemReadyM) begin
                    state_nxt    = M_WAIT;
                    wait_cnt_nxt = 5'd1;
                end
            end
            M_WAIT: begin
                if (hz.MemReadyM) begin
                    state_nxt    = M_IDLE;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == 5'(MEM_TIMEOUT - 1)) begin
                    state_nxt = M_ERR;
                end else begin
                    wait_cnt_nxt = wait_cnt + 5'd1;
                end
            end
            M_ERR: begin
                state_nxt = M_ERR;
            end
            default: begin
                state_nxt    = M_IDLE;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // Stall/flush outputs: a memory halt freezes everything and bubbles W;
    // otherwise load-use and control hazards drive the front end.
    always_comb begin
        stall_f   = 1'b0;
        hz.StallD = 1'b0;
        hz.StallE = 1'b0;
        hz.StallM = 1'b0;
        hz.FlushD = 1'b0;
        hz.FlushE = 1'b0;
        hz.FlushW = 1'b0;
        if (halt) begin
            stall_f   = 1'b1;
            hz.StallD = 1'b1;
            hz.StallE = 1'b1;
            hz.StallM = 1'b1;
            hz.FlushW = 1'b1;
        end else begin
            stall_f   = ld_stall || pc_pend;
            hz.StallD = ld_stall;
            hz.FlushD = pc_pend || hz.PCSrcW || hz.BranchTakenE;
            hz.FlushE = ld_stall || hz.BranchTakenE;
        end
    end

    assign hz.StallF = stall_f;

    // Saturating count of cycles with the fetch stage held.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall_f && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

    assign hz.StallCount = stall_count;
    assign hz.MemError   = (state == M_ERR);

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipeline: fetch, decode, execute, memory and writeback segments.
- Drives the stall (hold) and flush (bubble) controls of every pipeline segment register.
- Generates execute-stage operand forwarding selects.
- Runs a wait-state FSM for the multi-cycle data memory handshake.
- Keeps a saturating stall-cycle performance counter and a sticky memory-timeout error.

Parameters:
MEM_TIMEOUT, 16, maximum wait cycles for one data memory access before error.
CNT_W, 32, width of the stall-cycle counter.

Ports:
clk  in  1  pipeline clock; state updates on posedge.
rst  in  1  synchronous, active-high reset.
RA1D, RA2D  in  4  source register addresses in decode.
RA1E, RA2E  in  4  source register addresses in execute.
WA3E, WA3M, WA3W  in  4  destination register in execute / memory / writeback.
RegWriteM, RegWriteW  in  1  register write enable in memory / writeback.
MemtoRegE  in  1  load instruction in execute.
PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1  PC-writing instruction in each stage.
BranchTakenE  in  1  branch resolved taken in execute.
MemAccessM  in  1  load or store present in memory stage.
MemReadyM  in  1  data memory completes the access this cycle.
StallF, StallD, StallE, StallM  out  1  hold the corresponding segment register.
FlushD, FlushE, FlushW  out  1  zero the corresponding segment register.
ForwardAE, ForwardBE  out  2  operand select: 00 register file, 01 ResultW, 10 ALUOutM.
MemError  out  1  sticky timeout flag.
StallCount  out  CNT_W  cycles in which StallF was asserted.

Behaviour:
Timing
- clk and rst as listed: single clock, synchronous active-high reset.
- All outputs except MemError and StallCount are combinational from the inputs and the current FSM state. Zero latency: a hazard is visible in the same cycle.

Forwarding (combinational)
- ForwardAE = 10 if RegWriteM and WA3M==RA1E; else 01 if RegWriteW and WA3W==RA1E; else 00. The memory stage has priority.
- ForwardBE is identical using RA2E.
- Register 15 (PC) is never forwarded: a match on address 15 yields 00.

Hazard terms
- LdStall = MemtoRegE and (WA3E==RA1D or WA3E==RA2D).
- PCPend = PCSrcD or PCSrcE or PCSrcM.

Memory FSM
- States: M_IDLE, M_WAIT, M_ERR. A 5-bit wait counter WaitCnt.
- MemStall = MemAccessM and not MemReadyM, in M_IDLE or M_WAIT.
- M_IDLE:
  - MemAccessM and not MemReadyM -> M_WAIT, WaitCnt=1.
  - Zero-wait access (ready in the same cycle) stays in M_IDLE with no stall.
- M_WAIT:
  - MemReadyM -> M_IDLE. The stall drops that cycle so M/W captures the data.
  - Else if WaitCnt==MEM_TIMEOUT-1 -> M_ERR.
  - Else WaitCnt+1.
- M_ERR:
  - MemError=1.
  - StallF/D/E/M=1 and FlushW=1 permanently (pipeline halted).
  - Exits only on rst.

Output priority
1. M_ERR or MemStall:
   - StallF/D/E/M=1, FlushW=1 (a bubble enters writeback).
   - FlushD=0, FlushE=0 (freeze, not squash).
2. Otherwise:
   - StallF = LdStall or PCPend.
   - StallD = LdStall.
   - StallE = StallM = 0.
   - FlushD = PCPend or PCSrcW or BranchTakenE.
   - FlushE = LdStall or BranchTakenE.
   - FlushW = 0.

Simultaneous events
- LdStall with BranchTakenE: FlushE=1, StallD=1, FlushD=1. The branch squashes decode regardless.

StallCount
- Increments when StallF=1.
- Saturates at all-ones; no wrap.

Reset
- FSM=M_IDLE, WaitCnt=0, MemError=0, StallCount=0.
- rst asserted mid-wait abandons the access.
- Combinational outputs follow from the idle state: all stalls and flushes 0 with idle inputs.

Decomposition:
- Package hazard_pkg holds:
  - mem_state_t enum (M_IDLE, M_WAIT, M_ERR);
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - REG_PC=4'd15.
- One natural sub-module: forward_unit, the purely combinational per-operand select, instantiated twice (A and B).
- Stall, flush and FSM logic stay in the top module.

Test Plan:
- Forwarding: RegWriteM=1, WA3M=3, RegWriteW=1, WA3W=3, RA1E=3, RA2E=5 -> ForwardAE=10, ForwardBE=00. Then WA3M=7 -> ForwardAE=01. Addresses all 15 -> 00.
- Load-use: MemtoRegE=1, WA3E=2, RA2D=2 -> StallF=1, StallD=1, FlushE=1 for 1 cycle. StallCount increments by 1.
- Branch: PCSrcD pulse followed through E, M, W -> StallF=1 and FlushD=1 for 3 cycles, FlushD=1 in the W cycle. BranchTakenE=1 -> FlushD=FlushE=1.
- Memory wait: MemAccessM=1, MemReadyM low for 3 cycles then high -> StallF/D/E/M and FlushW high exactly 3 cycles, low on the ready cycle. Zero-wait access -> no stall.
- Timeout: MemReadyM held 0 with MEM_TIMEOUT=16 -> M_ERR after 16 stalled cycles, MemError=1 and stalls remain high. rst (sync) clears MemError and StallCount the next cycle.
- Reset mid-wait plus saturation: rst during M_WAIT -> M_IDLE, stalls 0. Preload StallCount to all-ones (CNT_W=4 build) and keep stalling -> stays 4'hF.
